// File: rtl/csr_bank_pkg.sv
// Shared types and helpers for the byte-addressed CSR bank.
package csr_bank_pkg;

    localparam int unsigned CSR_MAX_BYTES = 4;
    localparam int unsigned CSR_DATA_W    = 8 * CSR_MAX_BYTES;
    localparam int unsigned CSR_IDX_W     = 5;

    typedef enum logic [1:0] {
        CSR_RW  = 2'd0,
        CSR_RO  = 2'd1,
        CSR_W1C = 2'd2
    } csr_mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } csr_fsm_t;

    typedef struct packed {
        logic                 hit;
        logic [CSR_IDX_W-1:0] idx;
        logic [1:0]           lane;
        logic                 top;
    } csr_dec_t;

    // Bits of a register that exist for a given byte size.
    function automatic logic [CSR_DATA_W-1:0] csr_size_mask(input logic [2:0] size);
        case (size)
            3'd1:    return 32'h0000_00FF;
            3'd2:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [7:0] csr_byte(input logic [CSR_DATA_W-1:0] v, input logic [1:0] lane);
        return v[8*lane +: 8];
    endfunction

endpackage

// File: rtl/csr_reg_bank_if.sv
// Host byte-stream request/response channel of the CSR bank.
interface csr_reg_bank_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_write;
    logic [ADDR_W-1:0] i_req_addr;
    logic [7:0]        i_req_wdata;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [7:0]        o_rsp_rdata;

    modport master (
        output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata
    );

    modport slave (
        input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_rdata
    );
endinterface

// File: rtl/csr_addr_decode.sv
// Byte address to {hit, register index, lane, top-lane} decode; lowest index wins.
module csr_addr_decode
    import csr_bank_pkg::*;
#(
    parameter int unsigned             ADDR_W     = 9,
    parameter int unsigned             N_REGS     = 8,
    parameter logic [N_REGS*ADDR_W-1:0] REG_OFFSET = '0,
    parameter logic [N_REGS*3-1:0]      REG_SIZE   = {N_REGS{3'd2}}
) (
    input  logic [ADDR_W-1:0] addr,
    output csr_dec_t          dec
);
    localparam int unsigned AW1 = ADDR_W + 1;

    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] rel;
    logic [2:0]        sz;

    always_comb begin
        dec = '0;
        off = '0;
        rel = '0;
        sz  = '0;
        for (int i = N_REGS - 1; i >= 0; i--) begin
            off = REG_OFFSET[i*ADDR_W +: ADDR_W];
            sz  = REG_SIZE[i*3 +: 3];
            rel = addr - off;
            if (addr >= off && AW1'(addr) < AW1'(off) + AW1'(sz)) begin
                dec.hit  = 1'b1;
                dec.idx  = CSR_IDX_W'(i);
                dec.lane = 2'(rel);
                dec.top  = (rel == ADDR_W'(sz) - ADDR_W'(1));
            end
        end
    end
endmodule

// File: rtl/csr_reg_bank.sv
// Parametrised CSR bank: staged atomic multi-byte writes, snapshot reads, W1C status bits.
module csr_reg_bank
    import csr_bank_pkg::*;
#(
    parameter int unsigned              ADDR_W     = 9,
    parameter int unsigned              N_REGS     = 8,
    parameter logic [N_REGS*ADDR_W-1:0] REG_OFFSET = '0,
    parameter logic [N_REGS*3-1:0]      REG_SIZE   = {N_REGS{3'd2}},
    parameter logic [N_REGS*2-1:0]      REG_MODE   = {N_REGS{2'd0}},
    parameter logic [N_REGS*32-1:0]     REG_RESET  = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    csr_reg_bank_if.slave          bus,
    output logic [N_REGS*32-1:0]   o_reg_q,
    input  logic [N_REGS*32-1:0]   i_reg_d,
    input  logic [N_REGS*32-1:0]   i_w1c_set,
    output logic [N_REGS-1:0]      o_wr_stb,
    output logic [N_REGS-1:0]      o_rd_stb
);
    function automatic csr_mode_t mode_of(input int unsigned i);
        return csr_mode_t'(REG_MODE[i*2 +: 2]);
    endfunction

    function automatic logic [31:0] mask_of(input int unsigned i);
        return csr_size_mask(REG_SIZE[i*3 +: 3]);
    endfunction

    csr_dec_t    dec;
    csr_fsm_t    state;
    logic [31:0] reg_q   [N_REGS];
    logic [31:0] reg_nxt [N_REGS];
    logic [31:0] live    [N_REGS];

    logic [31:0]          stg_data;
    logic [3:0]           stg_lanes;
    logic                 stg_valid;
    logic [CSR_IDX_W-1:0] stg_idx;
    logic [31:0]          snap;
    logic                 snap_valid;
    logic [CSR_IDX_W-1:0] snap_idx;

    logic [31:0]       cur_val, cur_live, cur_mask, commit_val;
    csr_mode_t         cur_mode;
    logic [N_REGS-1:0] dec_onehot;
    logic [3:0]        lane_onehot;
    logic              req_fire, wr_ok, commit, stg_match;
    logic [7:0]        rd_byte;

    csr_addr_decode #(
        .ADDR_W    (ADDR_W),
        .N_REGS    (N_REGS),
        .REG_OFFSET(REG_OFFSET),
        .REG_SIZE  (REG_SIZE)
    ) u_decode (
        .addr(bus.i_req_addr),
        .dec (dec)
    );

    // Live view per register and the selected register's attributes.
    always_comb begin
        cur_val    = '0;
        cur_live   = '0;
        cur_mask   = '0;
        cur_mode   = CSR_RO;
        dec_onehot = '0;
        o_reg_q    = '0;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            live[i] = (mode_of(i) == CSR_RO) ? (i_reg_d[i*32 +: 32] & mask_of(i)) : reg_q[i];
            o_reg_q[i*32 +: 32] = (mode_of(i) == CSR_RO) ? 32'h0 : reg_q[i];
            if (dec.hit && dec.idx == CSR_IDX_W'(i)) begin
                dec_onehot[i] = 1'b1;
                cur_val       = reg_q[i];
                cur_live      = live[i];
                cur_mask      = mask_of(i);
                cur_mode      = mode_of(i);
            end
        end
    end

    // Commit value merges the current byte, staged lanes and the register's own bytes.
    always_comb begin
        req_fire    = bus.i_req_valid && bus.o_req_ready;
        wr_ok       = req_fire && bus.i_req_write && dec.hit && (cur_mode != CSR_RO);
        commit      = wr_ok && dec.top;
        stg_match   = stg_valid && (stg_idx == dec.idx);
        lane_onehot = 4'b0001 << dec.lane;
        commit_val  = '0;
        for (int j = 0; j < int'(CSR_MAX_BYTES); j++) begin
            if (dec.lane == 2'(j))
                commit_val[8*j +: 8] = bus.i_req_wdata;
            else if (stg_match && stg_lanes[j])
                commit_val[8*j +: 8] = stg_data[8*j +: 8];
            else
                commit_val[8*j +: 8] = cur_val[8*j +: 8];
        end
        commit_val = commit_val & cur_mask;

        if (!dec.hit)
            rd_byte = 8'h00;
        else if (dec.lane != 2'd0 && snap_valid && snap_idx == dec.idx)
            rd_byte = csr_byte(snap, dec.lane);
        else
            rd_byte = csr_byte(cur_live, dec.lane);
    end

    // Next register values: commit first, then W1C sets so a set wins over a clear.
    always_comb begin
        for (int unsigned i = 0; i < N_REGS; i++) begin
            reg_nxt[i] = reg_q[i];
            if (commit && dec.idx == CSR_IDX_W'(i)) begin
                if (mode_of(i) == CSR_W1C)
                    reg_nxt[i] = reg_q[i] & ~commit_val;
                else
                    reg_nxt[i] = commit_val;
            end
            if (mode_of(i) == CSR_W1C)
                reg_nxt[i] = reg_nxt[i] | (i_w1c_set[i*32 +: 32] & mask_of(i));
            if (mode_of(i) == CSR_RO)
                reg_nxt[i] = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= IDLE;
            bus.o_req_ready <= 1'b1;
            bus.o_rsp_valid <= 1'b0;
            bus.o_rsp_rdata <= '0;
            o_wr_stb        <= '0;
            o_rd_stb        <= '0;
            stg_data        <= '0;
            stg_lanes       <= '0;
            stg_valid       <= 1'b0;
            stg_idx         <= '0;
            snap            <= '0;
            snap_valid      <= 1'b0;
            snap_idx        <= '0;
            for (int unsigned i = 0; i < N_REGS; i++)
                reg_q[i] <= (mode_of(i) == CSR_RO) ? 32'h0 : (REG_RESET[i*32 +: 32] & mask_of(i));
        end else begin
            o_wr_stb <= '0;
            o_rd_stb <= '0;
            for (int unsigned i = 0; i < N_REGS; i++)
                reg_q[i] <= reg_nxt[i];

            if (commit) begin
                stg_valid <= 1'b0;
                stg_lanes <= '0;
                o_wr_stb  <= dec_onehot;
            end else if (wr_ok) begin
                stg_valid                   <= 1'b1;
                stg_idx                     <= dec.idx;
                stg_data[8*dec.lane +: 8]   <= bus.i_req_wdata;
                stg_lanes                   <= (stg_match ? stg_lanes : 4'b0000) | lane_onehot;
            end

            case (state)
                IDLE: begin
                    if (req_fire && !bus.i_req_write) begin
                        state           <= RESP;
                        bus.o_req_ready <= 1'b0;
                        bus.o_rsp_valid <= 1'b1;
                        bus.o_rsp_rdata <= rd_byte;
                        if (dec.hit && dec.lane == 2'd0) begin
                            snap       <= cur_live;
                            snap_valid <= 1'b1;
                            snap_idx   <= dec.idx;
                            o_rd_stb   <= dec_onehot;
                        end
                    end
                end
                RESP: begin
                    if (bus.i_rsp_ready) begin
                        state           <= IDLE;
                        bus.o_req_ready <= 1'b1;
                        bus.o_rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csr_reg_bank.sv
// Directed table-driven bench for csr_reg_bank with a 4-register map (RW4, RW2, RO4, W1C1).
module tb_csr_reg_bank;
    import csr_bank_pkg::*;

    localparam int unsigned AW = 9;
    localparam int unsigned NR = 4;
    localparam logic [NR*AW-1:0] OFFS  = {9'h040, 9'h030, 9'h022, 9'h010};
    localparam logic [NR*3-1:0]  SIZES = {3'd1, 3'd4, 3'd2, 3'd4};
    localparam logic [NR*2-1:0]  MODES = {2'd2, 2'd1, 2'd0, 2'd0};
    localparam logic [NR*32-1:0] RESETS = {32'hFFFF_FF00, 32'h0, 32'h0000_5A5A, 32'h1234_5678};

    logic              clk, rst;
    logic [NR*32-1:0]  reg_q, reg_d, w1c_set;
    logic [NR-1:0]     wr_stb, rd_stb;
    int                checks = 0;
    int                failures = 0;

    csr_reg_bank_if #(.ADDR_W(AW)) bus ();

    csr_reg_bank #(
        .ADDR_W(AW), .N_REGS(NR), .REG_OFFSET(OFFS),
        .REG_SIZE(SIZES), .REG_MODE(MODES), .REG_RESET(RESETS)
    ) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus),
        .o_reg_q(reg_q), .i_reg_d(reg_d), .i_w1c_set(w1c_set),
        .o_wr_stb(wr_stb), .o_rd_stb(rd_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        wr;
        logic [8:0]  addr;
        logic [7:0]  wdata;
        logic [31:0] regd;
        logic [7:0]  exp_rd;
        int          ridx;
        logic [31:0] exp_reg;
        logic [3:0]  exp_wstb;
        logic [3:0]  exp_rstb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic wr, input logic [8:0] a,
                                input logic [7:0] d, input logic [31:0] rdv, input logic [7:0] er,
                                input int ri, input logic [31:0] ev, input logic [3:0] ws,
                                input logic [3:0] rs);
        vec_t v;
        v.name = nm; v.wr = wr; v.addr = a; v.wdata = d; v.regd = rdv; v.exp_rd = er;
        v.ridx = ri; v.exp_reg = ev; v.exp_wstb = ws; v.exp_rstb = rs;
        return v;
    endfunction

    function automatic logic [31:0] rq(input int i);
        return reg_q[i*32 +: 32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.o_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout actual=0 expected=1");
        end
    endtask

    // Present one request at a negedge; return #1 after the accepting edge.
    task automatic issue(input logic wr, input logic [8:0] a, input logic [7:0] d);
        wait_ready();
        bus.i_req_valid = 1'b1;
        bus.i_req_write = wr;
        bus.i_req_addr  = a;
        bus.i_req_wdata = d;
        @(posedge clk);
        #1;
        bus.i_req_valid = 1'b0;
    endtask

    initial begin
        vecs.push_back(mk("rd_r0_l0",     0, 9'h010, 8'h00, 32'hFF,  8'h78, 0, 32'h1234_5678, 4'b0000, 4'b0001));
        vecs.push_back(mk("rd_r0_l1",     0, 9'h011, 8'h00, 32'hFF,  8'h56, 0, 32'h1234_5678, 4'b0000, 4'b0000));
        vecs.push_back(mk("rd_r0_l2",     0, 9'h012, 8'h00, 32'hFF,  8'h34, 0, 32'h1234_5678, 4'b0000, 4'b0000));
        vecs.push_back(mk("rd_r0_l3",     0, 9'h013, 8'h00, 32'hFF,  8'h12, 0, 32'h1234_5678, 4'b0000, 4'b0000));
        vecs.push_back(mk("wr_r1_l0",     1, 9'h022, 8'hCD, 32'hFF,  8'h00, 1, 32'h0000_5A5A, 4'b0000, 4'b0000));
        vecs.push_back(mk("wr_r1_l1",     1, 9'h023, 8'hAB, 32'hFF,  8'h00, 1, 32'h0000_ABCD, 4'b0010, 4'b0000));
        vecs.push_back(mk("rd_ro_l0",     0, 9'h030, 8'h00, 32'hFF,  8'hFF, 2, 32'h0,         4'b0000, 4'b0100));
        vecs.push_back(mk("rd_ro_l1",     0, 9'h031, 8'h00, 32'h100, 8'h00, 2, 32'h0,         4'b0000, 4'b0000));
        vecs.push_back(mk("rd_ro_l2",     0, 9'h032, 8'h00, 32'h100, 8'h00, 2, 32'h0,         4'b0000, 4'b0000));
        vecs.push_back(mk("rd_ro_l3",     0, 9'h033, 8'h00, 32'h100, 8'h00, 2, 32'h0,         4'b0000, 4'b0000));
        vecs.push_back(mk("rd_unmapped",  0, 9'h1FF, 8'h00, 32'h100, 8'h00, 0, 32'h1234_5678, 4'b0000, 4'b0000));
        vecs.push_back(mk("wr_unmapped",  1, 9'h1FF, 8'h55, 32'h100, 8'h00, 0, 32'h1234_5678, 4'b0000, 4'b0000));
        vecs.push_back(mk("wr_ro",        1, 9'h033, 8'hAA, 32'h100, 8'h00, 2, 32'h0,         4'b0000, 4'b0000));
        vecs.push_back(mk("rd_r1_l0",     0, 9'h022, 8'h00, 32'h100, 8'hCD, 1, 32'h0000_ABCD, 4'b0000, 4'b0010));
        vecs.push_back(mk("rd_r1_l1",     0, 9'h023, 8'h00, 32'h100, 8'hAB, 1, 32'h0000_ABCD, 4'b0000, 4'b0000));
        vecs.push_back(mk("wr_r0_top",    1, 9'h013, 8'h99, 32'h100, 8'h00, 0, 32'h9934_5678, 4'b0001, 4'b0000));
        vecs.push_back(mk("wr_r0_stage",  1, 9'h010, 8'h11, 32'h100, 8'h00, 0, 32'h9934_5678, 4'b0000, 4'b0000));
        vecs.push_back(mk("wr_r1_retag",  1, 9'h022, 8'hEE, 32'h100, 8'h00, 1, 32'h0000_ABCD, 4'b0000, 4'b0000));
        vecs.push_back(mk("wr_r0_lost",   1, 9'h013, 8'h77, 32'h100, 8'h00, 0, 32'h7734_5678, 4'b0001, 4'b0000));
        vecs.push_back(mk("wr_r1_clr",    1, 9'h023, 8'h00, 32'h100, 8'h00, 1, 32'h0000_00CD, 4'b0010, 4'b0000));
        vecs.push_back(mk("wr_r0_b0",     1, 9'h010, 8'h01, 32'h100, 8'h00, 0, 32'h7734_5678, 4'b0000, 4'b0000));
        vecs.push_back(mk("wr_r0_b1",     1, 9'h011, 8'h02, 32'h100, 8'h00, 0, 32'h7734_5678, 4'b0000, 4'b0000));
        vecs.push_back(mk("wr_r0_b2",     1, 9'h012, 8'h03, 32'h100, 8'h00, 0, 32'h7734_5678, 4'b0000, 4'b0000));
        vecs.push_back(mk("wr_r0_b3",     1, 9'h013, 8'h04, 32'h100, 8'h00, 0, 32'h0403_0201, 4'b0001, 4'b0000));
        vecs.push_back(mk("rd_ro_new",    0, 9'h030, 8'h00, 32'h100, 8'h00, 2, 32'h0,         4'b0000, 4'b0100));
        vecs.push_back(mk("rd_r0_live",   0, 9'h011, 8'h00, 32'h100, 8'h02, 0, 32'h0403_0201, 4'b0000, 4'b0000));
        vecs.push_back(mk("rd_ro_snap",   0, 9'h031, 8'h00, 32'h100, 8'h01, 2, 32'h0,         4'b0000, 4'b0000));

        rst = 1'b1;
        reg_d = '0;
        w1c_set = '0;
        reg_d[64 +: 32] = 32'hFF;
        bus.i_req_valid = 1'b0;
        bus.i_req_write = 1'b0;
        bus.i_req_addr  = '0;
        bus.i_req_wdata = '0;
        bus.i_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_r0", rq(0), 32'h1234_5678);
        chk("rst_r1", rq(1), 32'h0000_5A5A);
        chk("rst_r2", rq(2), 32'h0);
        chk("rst_r3_masked", rq(3), 32'h0);
        chk("rst_req_ready", 32'(bus.o_req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
        chk("rst_rdata", 32'(bus.o_rsp_rdata), 32'h0);
        chk("rst_strobes", {24'h0, wr_stb, rd_stb}, 32'h0);
        rst = 1'b0;

        foreach (vecs[n]) begin
            reg_d[64 +: 32] = vecs[n].regd;
            issue(vecs[n].wr, vecs[n].addr, vecs[n].wdata);
            if (!vecs[n].wr) begin
                chk({vecs[n].name, "_valid"}, 32'(bus.o_rsp_valid), 32'h1);
                chk({vecs[n].name, "_rdata"}, 32'(bus.o_rsp_rdata), 32'(vecs[n].exp_rd));
            end
            chk({vecs[n].name, "_reg"},  rq(vecs[n].ridx), vecs[n].exp_reg);
            chk({vecs[n].name, "_wstb"}, 32'(wr_stb), 32'(vecs[n].exp_wstb));
            chk({vecs[n].name, "_rstb"}, 32'(rd_stb), 32'(vecs[n].exp_rstb));
        end

        // Backpressure hold, then reset mid-hold drops the response and staging.
        issue(1'b1, 9'h022, 8'h11);
        bus.i_rsp_ready = 1'b0;
        issue(1'b0, 9'h010, 8'h00);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(bus.o_rsp_valid), 32'h1);
            chk("bp_rdata", 32'(bus.o_rsp_rdata), 32'h01);
            chk("bp_req_ready", 32'(bus.o_req_ready), 32'h0);
            chk("bp_rstb", 32'(rd_stb), (k == 0) ? 32'h1 : 32'h0);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.i_rsp_ready = 1'b1;
        chk("bp_rst_valid", 32'(bus.o_rsp_valid), 32'h0);
        chk("bp_rst_ready", 32'(bus.o_req_ready), 32'h1);
        chk("bp_rst_rdata", 32'(bus.o_rsp_rdata), 32'h0);
        chk("bp_rst_r0", rq(0), 32'h1234_5678);
        issue(1'b1, 9'h023, 8'h22);
        chk("stg_lost_r1", rq(1), 32'h0000_225A);
        chk("stg_lost_wstb", 32'(wr_stb), 32'h2);

        // W1C: set (upper bits masked), clear by write-1, set beats same-cycle clear.
        @(negedge clk);
        w1c_set[96 +: 32] = 32'h0000_0108;
        @(posedge clk);
        #1;
        w1c_set = '0;
        chk("w1c_set", rq(3), 32'h08);
        issue(1'b1, 9'h040, 8'h01);
        chk("w1c_wr0_keep", rq(3), 32'h08);
        chk("w1c_wr0_wstb", 32'(wr_stb), 32'h8);
        issue(1'b1, 9'h040, 8'h08);
        chk("w1c_clear", rq(3), 32'h00);
        wait_ready();
        w1c_set[96 +: 32] = 32'h0000_0008;
        bus.i_req_valid = 1'b1;
        bus.i_req_write = 1'b1;
        bus.i_req_addr  = 9'h040;
        bus.i_req_wdata = 8'h08;
        @(posedge clk);
        #1;
        bus.i_req_valid = 1'b0;
        w1c_set = '0;
        chk("w1c_set_wins", rq(3), 32'h08);
        chk("w1c_set_wins_wstb", 32'(wr_stb), 32'h8);
        issue(1'b0, 9'h040, 8'h00);
        chk("w1c_rd_rdata", 32'(bus.o_rsp_rdata), 32'h08);
        chk("w1c_rd_rstb", 32'(rd_stb), 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
